rb_cfg_bank_p: RTL

Parametrised configuration/status register bank on the byte-wide register bus. It generalises the fixed-map register block:
- configurable count of read/write config bytes and sticky W1C status bytes, with per-byte reset values;
- a control register with a commit strobe and interrupt enable;
- a registered interrupt output.

It sits between the bus master (SPI/UART bridge) and the datapath, driving flattened config vectors and collecting event flags.

---
 rtl/rb_cfg_pkg.sv | 47 ++++
 rtl/rb_cfg_bank_p_sticky.sv | 31 +++
 rtl/rb_cfg_bank_p.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rb_cfg_pkg.sv
// Shared definitions for the parametrised register bank: CTRL bit positions,
// access classes and the address decoder.
package rb_cfg_pkg;

    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned IDX_W           = 8;

    typedef enum logic [1:0] {
        RB_RW   = 2'd0,
        RB_W1C  = 2'd1,
        RB_CTRL = 2'd2,
        RB_NONE = 2'd3
    } rb_access_t;

    typedef struct packed {
        rb_access_t       acc;
        logic [IDX_W-1:0] idx;
    } rb_dec_t;

    // Map an absolute bus address to its access class and byte index.
    function automatic rb_dec_t rb_decode(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] num_rw,
        input logic [31:0] num_stat
    );
        rb_dec_t     dec;
        logic [31:0] off;
        dec.acc = RB_NONE;
        dec.idx = '0;
        off     = addr - base;
        if (addr >= base) begin
            if (off < num_rw) begin
                dec.acc = RB_RW;
                dec.idx = IDX_W'(off);
            end else if (off < num_rw + num_stat) begin
                dec.acc = RB_W1C;
                dec.idx = IDX_W'(off - num_rw);
            end else if (off == num_rw + num_stat) begin
                dec.acc = RB_CTRL;
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/rb_cfg_bank_p_sticky.sv
// Eight sticky event bits with write-one-to-clear; a set in the same cycle
// as a clear wins so no event is lost.
module rb_sticky_byte (
    input  logic       clk,
    input  logic       resetb,
    input  logic [7:0] set,
    input  logic       clr_wr,
    input  logic [7:0] clr_data,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;
    logic [7:0] clr_mask_c;

    always_comb begin
        clr_mask_c = clr_wr ? clr_data : 8'h00;
        q_d        = (q_q & ~clr_mask_c) | set;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rb_cfg_bank_p.sv
// Parametrised config/status register bank on the byte-wide register bus.
// Optional shadowed config with commit is enabled by defining RB_CFG_SHADOW_EN.
module rb_cfg_bank_p
    import rb_cfg_pkg::*;
#(
    parameter int unsigned           ADR_BITS  = 8,
    parameter int unsigned           NUM_RW    = 4,
    parameter int unsigned           NUM_STAT  = 2,
    parameter int unsigned           BASE_ADDR = 0,
    parameter logic [NUM_RW*8-1:0]   RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic [ADR_BITS-1:0]      address,
    input  logic [7:0]               data_write_in,
    output logic [7:0]               data_read_out,
    input  logic                     reg_en,
    input  logic                     write_en,
    output logic [NUM_RW*8-1:0]      cfg_out,
    input  logic [NUM_STAT*8-1:0]    stat_in,
    output logic                     irq,
    output logic                     commit_pulse
);

    localparam int unsigned CFG_W  = NUM_RW * 8;
    localparam int unsigned STAT_W = NUM_STAT * 8;

    rb_dec_t             dec_c;
    logic                wr_c;
    logic [CFG_W-1:0]    cfg_q;
    logic [CFG_W-1:0]    cfg_d;
    logic [CFG_W-1:0]    cfg_rd_c;
    logic [STAT_W-1:0]   stat_q;
    logic [NUM_STAT-1:0] stat_clr_c;
    logic                irq_en_q;
    logic                irq_en_d;
    logic                irq_q;
    logic                irq_d;
    logic [7:0]          rdata_q;
    logic [7:0]          rdata_d;

    assign dec_c = rb_decode(32'(address), 32'(BASE_ADDR), 32'(NUM_RW), 32'(NUM_STAT));
    assign wr_c  = reg_en & write_en;

`ifdef RB_CFG_SHADOW_EN
    logic [CFG_W-1:0] shadow_q;
    logic [CFG_W-1:0] shadow_d;
    logic             commit_req_q;
    logic             commit_req_d;
    logic             commit_pulse_q;
    logic             commit_pulse_d;

    // Bus writes land in the shadow; a commit copies it one edge later.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_c && (dec_c.acc == RB_RW) && (dec_c.idx == IDX_W'(i))) begin
                shadow_d[8*i +: 8] = data_write_in;
            end
        end
        commit_req_d   = wr_c && (dec_c.acc == RB_CTRL) && data_write_in[CTRL_COMMIT_BIT];
        commit_pulse_d = commit_req_q;
        cfg_d          = commit_req_q ? shadow_q : cfg_q;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shadow_q       <= RESET_VAL;
            commit_req_q   <= 1'b0;
            commit_pulse_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            commit_req_q   <= commit_req_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    assign cfg_rd_c     = shadow_q;
    assign commit_pulse = commit_pulse_q;
`else
    always_comb begin
        cfg_d = cfg_q;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_c && (dec_c.acc == RB_RW) && (dec_c.idx == IDX_W'(i))) begin
                cfg_d[8*i +: 8] = data_write_in;
            end
        end
    end

    assign cfg_rd_c     = cfg_q;
    assign commit_pulse = 1'b0;
`endif

    for (genvar j = 0; j < NUM_STAT; j++) begin : g_stat
        assign stat_clr_c[j] = wr_c && (dec_c.acc == RB_W1C) && (dec_c.idx == IDX_W'(j));

        rb_sticky_byte u_sticky (
            .clk      (clk),
            .resetb   (resetb),
            .set      (stat_in[8*j +: 8]),
            .clr_wr   (stat_clr_c[j]),
            .clr_data (data_write_in),
            .q        (stat_q[8*j +: 8])
        );
    end

    // CTRL, interrupt and read-data next state; reads see pre-edge values.
    always_comb begin
        irq_en_d = irq_en_q;
        rdata_d  = rdata_q;
        irq_d    = irq_en_q & (|stat_q);
        if (wr_c && (dec_c.acc == RB_CTRL)) begin
            irq_en_d = data_write_in[CTRL_IRQ_EN_BIT];
        end
        if (reg_en) begin
            rdata_d = 8'h00;
            case (dec_c.acc)
                RB_RW: begin
                    for (int i = 0; i < NUM_RW; i++) begin
                        if (dec_c.idx == IDX_W'(i)) begin
                            rdata_d = cfg_rd_c[8*i +: 8];
                        end
                    end
                end
                RB_W1C: begin
                    for (int j = 0; j < NUM_STAT; j++) begin
                        if (dec_c.idx == IDX_W'(j)) begin
                            rdata_d = stat_q[8*j +: 8];
                        end
                    end
                end
                RB_CTRL: rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
                default: rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cfg_q    <= RESET_VAL;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            cfg_q    <= cfg_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cfg_out       = cfg_q;
    assign irq           = irq_q;
    assign data_read_out = rdata_q;

endmodule
